// File: rtl/verificador_senhas_multi.sv
// verificador_senhas_multi
// Checks an entered digit buffer against up to N_SENHAS stored passwords.
// Each password has variable length and is padded with 0xF. It may appear
// anywhere in the entry as a contiguous substring. The block reports the
// matching slot, counts consecutive failures and enforces a tick-driven
// lockout.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   valid_in      one-cycle pulse: verify the entry currently on the inputs
//   senha_teste   entry digits, digit i at [4i+3:4i], 0xF = empty
//   senhas_reais  stored passwords, slot s digit k at [(s*N_MAX+k)*4 +: 4]
//   slot_en       per-slot enable mask
//   tick          lockout time base strobe
//   busy          verification in progress (low only in IDLE)
//   done          one-cycle result strobe
//   senha_ok      last result correct, held until next accepted valid_in
//   match_idx     matching slot, held with senha_ok
//   falhas        consecutive failure count
//   bloqueado     lockout active
module verificador_senhas_multi #(
    parameter int N_TESTE    = 20,
    parameter int N_MAX      = 12,
    parameter int N_MIN      = 4,
    parameter int N_SENHAS   = 4,
    parameter int MAX_FALHAS = 5,
    parameter int T_BLOQUEIO = 30,
    localparam int IW = (N_SENHAS > 1) ? $clog2(N_SENHAS) : 1,
    localparam int FW = $clog2(MAX_FALHAS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [4*N_TESTE-1:0]         senha_teste,
    input  logic [N_SENHAS*4*N_MAX-1:0]  senhas_reais,
    input  logic [N_SENHAS-1:0]          slot_en,
    input  logic                         tick,
    output logic                         busy,
    output logic                         done,
    output logic                         senha_ok,
    output logic [IW-1:0]                match_idx,
    output logic [FW-1:0]                falhas,
    output logic                         bloqueado
);

    localparam int PW = $clog2(N_TESTE + 1);
    localparam int LW = $clog2(N_MAX + 1);
    localparam int CW = $clog2(T_BLOQUEIO + 1);

    typedef enum logic [2:0] {IDLE, LEN, SCAN, OK, FAIL, REJ} state_t;

    state_t state, next_state;

    logic [4*N_TESTE-1:0]        teste_r;
    logic [N_SENHAS*4*N_MAX-1:0] reais_r;
    logic [N_SENHAS-1:0]         en_r;
    logic [LW-1:0]               len_c [N_SENHAS];
    logic [LW-1:0]               len_r [N_SENHAS];
    logic [N_SENHAS-1:0]         slot_val_r;
    logic [IW-1:0]               s_r;
    logic [PW-1:0]               p_r;
    logic [CW-1:0]               lock_cnt;

    logic [LW-1:0] cur_len;
    logic          cur_val;
    logic          fits;
    logic          at_end;
    logic          digits_eq;
    logic          hit;
    logic          last_slot;

    // Password length = index of the first 0xF digit, or N_MAX if none.
    // This is computed on the captured copy, so the inputs may change freely.
    always_comb begin
        for (int s = 0; s < N_SENHAS; s++) begin
            len_c[s] = LW'(N_MAX);
            for (int k = N_MAX - 1; k >= 0; k--) begin
                if (reais_r[(s*N_MAX + k)*4 +: 4] == 4'hF) begin
                    len_c[s] = LW'(k);
                end
            end
        end
    end

    // Single (slot, offset) comparison per cycle.
    // Digits beyond the entry buffer never match.
    always_comb begin
        cur_len   = len_r[s_r];
        cur_val   = slot_val_r[s_r];
        fits      = (int'(p_r) + int'(cur_len)) <= N_TESTE;
        at_end    = (int'(p_r) + int'(cur_len)) >= N_TESTE;
        last_slot = (int'(s_r) == N_SENHAS - 1);
        digits_eq = 1'b1;
        for (int k = 0; k < N_MAX; k++) begin
            if (k < int'(cur_len)) begin
                if (int'(p_r) + k < N_TESTE) begin
                    if (reais_r[(int'(s_r)*N_MAX + k)*4 +: 4] !=
                        teste_r[(int'(p_r) + k)*4 +: 4]) begin
                        digits_eq = 1'b0;
                    end
                end else begin
                    digits_eq = 1'b0;
                end
            end
        end
        hit = cur_val && fits && digits_eq;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    next_state = bloqueado ? REJ : LEN;
                end
            end
            LEN:  next_state = SCAN;
            SCAN: begin
                if (hit) begin
                    next_state = OK;
                end else if ((!cur_val || at_end) && last_slot) begin
                    next_state = FAIL;
                end
            end
            OK, FAIL, REJ: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state != IDLE);
        done = (state == OK) || (state == FAIL) || (state == REJ);
    end

    // Datapath: capture, slot setup, scan pointers, result and failure bookkeeping.
    // Result registers are updated on the edge that enters OK/FAIL/REJ. This way
    // senha_ok, falhas and bloqueado already hold their new values while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            teste_r    <= '0;
            reais_r    <= '0;
            en_r       <= '0;
            slot_val_r <= '0;
            s_r        <= '0;
            p_r        <= '0;
            senha_ok   <= 1'b0;
            match_idx  <= '0;
            falhas     <= '0;
            bloqueado  <= 1'b0;
            lock_cnt   <= '0;
            for (int i = 0; i < N_SENHAS; i++) begin
                len_r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        senha_ok <= 1'b0;
                        if (!bloqueado) begin
                            teste_r   <= senha_teste;
                            reais_r   <= senhas_reais;
                            en_r      <= slot_en;
                            match_idx <= '0;
                        end
                    end
                end
                LEN: begin
                    for (int i = 0; i < N_SENHAS; i++) begin
                        len_r[i]      <= len_c[i];
                        slot_val_r[i] <= en_r[i] && (int'(len_c[i]) >= N_MIN);
                    end
                    s_r <= '0;
                    p_r <= '0;
                end
                SCAN: begin
                    if (hit) begin
                        senha_ok  <= 1'b1;
                        match_idx <= s_r;
                        falhas    <= '0;
                    end else if (!cur_val || at_end) begin
                        p_r <= '0;
                        if (last_slot) begin
                            senha_ok <= 1'b0;
                            falhas   <= falhas + 1'b1;
                            if (falhas == FW'(MAX_FALHAS - 1)) begin
                                bloqueado <= 1'b1;
                                lock_cnt  <= CW'(T_BLOQUEIO);
                            end
                        end else begin
                            s_r <= s_r + 1'b1;
                        end
                    end else begin
                        p_r <= p_r + 1'b1;
                    end
                end
                default: ;
            endcase

            // Lockout countdown.
            // Releasing the lock also forgives the failure history.
            if (bloqueado && tick) begin
                if (lock_cnt <= CW'(1)) begin
                    lock_cnt  <= '0;
                    bloqueado <= 1'b0;
                    falhas    <= '0;
                end else begin
                    lock_cnt <= lock_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_verificador_senhas_multi.sv
// tb_verificador_senhas_multi
// Self-checking bench for verificador_senhas_multi.
// It uses a default instance and a small one (N_SENHAS=1, N_TESTE=8).
// Each stimulus pushes its expected result, including the expected done cycle,
// into a queue. A monitor pops that expectation and compares it whenever done
// is seen.
module tb_verificador_senhas_multi;

    typedef struct {
        logic       ok;
        logic [1:0] idx;
        logic [2:0] fal;
        logic       bloq;
        int         cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;

    logic         valid_in;
    logic [79:0]  senha_teste;
    logic [191:0] senhas_reais;
    logic [3:0]   slot_en;
    logic         busy, done, senha_ok, bloqueado;
    logic [1:0]   match_idx;
    logic [2:0]   falhas;

    logic         valid_in_s;
    logic [31:0]  senha_teste_s;
    logic [47:0]  senhas_reais_s;
    logic [0:0]   slot_en_s;
    logic         busy_s, done_s, senha_ok_s, bloqueado_s;
    logic [0:0]   match_idx_s;
    logic [2:0]   falhas_s;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   sim_done = 1'b0;
    exp_t q_main[$];
    exp_t q_small[$];

    verificador_senhas_multi dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .senha_teste(senha_teste),
        .senhas_reais(senhas_reais), .slot_en(slot_en), .tick(tick),
        .busy(busy), .done(done), .senha_ok(senha_ok), .match_idx(match_idx),
        .falhas(falhas), .bloqueado(bloqueado)
    );

    verificador_senhas_multi #(.N_TESTE(8), .N_SENHAS(1)) dut_small (
        .clk(clk), .rst(rst), .valid_in(valid_in_s), .senha_teste(senha_teste_s),
        .senhas_reais(senhas_reais_s), .slot_en(slot_en_s), .tick(tick),
        .busy(busy_s), .done(done_s), .senha_ok(senha_ok_s), .match_idx(match_idx_s),
        .falhas(falhas_s), .bloqueado(bloqueado_s)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected done strobes.
    always @(posedge clk) cyc <= cyc + 1;

    // Places n hex digits of v (most significant first) starting at digit off,
    // with every other digit set to 0xF.
    function automatic logic [79:0] digs(input int off, input int n, input logic [47:0] v);
        logic [79:0] r;
        r = '1;
        for (int i = 0; i < n; i++) begin
            r[(off + i)*4 +: 4] = v[(n - 1 - i)*4 +: 4];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setSlot(input int s, input int n, input logic [47:0] v);
        logic [79:0] tmp;
        tmp = digs(0, n, v);
        senhas_reais[s*48 +: 48] = tmp[47:0];
    endtask

    task automatic applyStimulus(input logic [79:0] t, input logic ok, input logic [1:0] idx,
                                 input logic [2:0] fal, input logic bloq, input int lat);
        exp_t e;
        @(negedge clk);
        senha_teste = t;
        valid_in    = 1'b1;
        e.ok = ok; e.idx = idx; e.fal = fal; e.bloq = bloq; e.cyc = cyc + lat;
        q_main.push_back(e);
        @(negedge clk);
        valid_in    = 1'b0;
        senha_teste = '1;
    endtask

    task automatic applyStimulusSmall(input logic [79:0] t, input logic ok,
                                      input logic [2:0] fal, input int lat);
        exp_t e;
        @(negedge clk);
        senha_teste_s = t[31:0];
        valid_in_s    = 1'b1;
        e.ok = ok; e.idx = 2'd0; e.fal = fal; e.bloq = 1'b0; e.cyc = cyc + lat;
        q_small.push_back(e);
        @(negedge clk);
        valid_in_s    = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((q_main.size() != 0 || q_small.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q_main.size() != 0 || q_small.size() != 0) begin
            checkOutput("done_timeout", 32'(q_main.size() + q_small.size()), 0);
            q_main.delete();
            q_small.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic tickPulses(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    // Monitor: each done strobe must line up with the oldest expectation.
    task automatic monitor();
        exp_t e;
        while (!sim_done) begin
            @(negedge clk);
            if (done) begin
                if (q_main.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = q_main.pop_front();
                    checkOutput("senha_ok",  32'(senha_ok),  32'(e.ok));
                    checkOutput("match_idx", 32'(match_idx), 32'(e.idx));
                    checkOutput("falhas",    32'(falhas),    32'(e.fal));
                    checkOutput("bloqueado", 32'(bloqueado), 32'(e.bloq));
                    checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (done_s) begin
                if (q_small.size() == 0) begin
                    checkOutput("unexpected_done_small", 1, 0);
                end else begin
                    e = q_small.pop_front();
                    checkOutput("small_senha_ok",  32'(senha_ok_s),  32'(e.ok));
                    checkOutput("small_match_idx", 32'(match_idx_s), 32'(e.idx));
                    checkOutput("small_falhas",    32'(falhas_s),    32'(e.fal));
                    checkOutput("small_done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    task automatic stimulus();
        logic [79:0] tmp;
        rst = 1'b1; tick = 1'b0;
        valid_in = 1'b0; senha_teste = '1; senhas_reais = '1; slot_en = '0;
        valid_in_s = 1'b0; senha_teste_s = '1; senhas_reais_s = '1; slot_en_s = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",      32'(busy),      0);
        checkOutput("rst_done",      32'(done),      0);
        checkOutput("rst_senha_ok",  32'(senha_ok),  0);
        checkOutput("rst_falhas",    32'(falhas),    0);
        checkOutput("rst_bloqueado", 32'(bloqueado), 0);
        rst = 1'b0;
        @(negedge clk);

        // Slot 0 = 1234, entry 9,9,1,2,3,4: match at offset 2.
        setSlot(0, 4, 48'h1234);
        slot_en = 4'b0001;
        applyStimulus(digs(0, 6, 48'h991234), 1'b1, 2'd0, 3'd0, 1'b0, 5);
        waitIdle();

        // Slots 0,1 disabled, slot 2 too short, slot 3 = 56789 at end of buffer.
        setSlot(1, 4, 48'h1234);
        setSlot(2, 3, 48'h567);
        setSlot(3, 5, 48'h56789);
        slot_en = 4'b1100;
        applyStimulus(digs(15, 5, 48'h56789), 1'b1, 2'd3, 3'd0, 1'b0, 21);
        waitIdle();
        // Shifted to offset 16 the password no longer fits.
        applyStimulus(digs(16, 4, 48'h5678), 1'b0, 2'd0, 3'd1, 1'b0, 21);
        waitIdle();
        applyStimulus(digs(16, 4, 48'h5678), 1'b0, 2'd0, 3'd2, 1'b0, 21);
        waitIdle();
        applyStimulus(digs(16, 4, 48'h5678), 1'b0, 2'd0, 3'd3, 1'b0, 21);
        waitIdle();

        // Slots 1 and 3 both match: the lowest slot wins and failures clear.
        setSlot(0, 4, 48'h1111);
        setSlot(1, 4, 48'h2468);
        setSlot(2, 0, 48'h0);
        setSlot(3, 4, 48'h2468);
        slot_en = 4'b1111;
        applyStimulus(digs(0, 4, 48'h2468), 1'b1, 2'd1, 3'd0, 1'b0, 20);
        waitIdle();

        // Five consecutive failures lead to lockout.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(digs(0, 4, 48'h9999), 1'b0, 2'd0, 3'(i), (i == 5), 54);
            waitIdle();
        end
        // Locked: rejected immediately.
        applyStimulus(digs(0, 4, 48'h2468), 1'b0, 2'd0, 3'd5, 1'b1, 1);
        waitIdle();
        tickPulses(29);
        @(negedge clk);
        checkOutput("lock_29_ticks", 32'(bloqueado), 1);
        checkOutput("falhas_29_ticks", 32'(falhas), 5);
        tickPulses(1);
        @(negedge clk);
        checkOutput("lock_30_ticks", 32'(bloqueado), 0);
        checkOutput("falhas_30_ticks", 32'(falhas), 0);

        // Second valid_in during SCAN is ignored.
        applyStimulus(digs(10, 4, 48'h2468), 1'b1, 2'd1, 3'd0, 1'b0, 30);
        repeat (4) @(negedge clk);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        waitIdle();
        repeat (40) @(negedge clk);

        // One failure, then reset in the middle of a scan.
        applyStimulus(digs(0, 4, 48'h9999), 1'b0, 2'd0, 3'd1, 1'b0, 54);
        waitIdle();
        applyStimulus(digs(10, 4, 48'h2468), 1'b1, 2'd1, 3'd0, 1'b0, 30);
        repeat (8) @(negedge clk);
        checkOutput("busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy",      32'(busy),      0);
        checkOutput("midrst_done",      32'(done),      0);
        checkOutput("midrst_falhas",    32'(falhas),    0);
        checkOutput("midrst_bloqueado", 32'(bloqueado), 0);
        checkOutput("midrst_senha_ok",  32'(senha_ok),  0);
        q_main.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);

        // Small instance: 4-digit password at offset 4, then a miss.
        tmp = digs(0, 4, 48'h1357);
        senhas_reais_s = tmp[47:0];
        slot_en_s = 1'b1;
        applyStimulusSmall(digs(4, 4, 48'h1357), 1'b1, 3'd0, 7);
        waitIdle();
        applyStimulusSmall(digs(0, 4, 48'h2222), 1'b0, 3'd1, 7);
        waitIdle();

        sim_done = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
